// File: rtl/common_types_pkg.sv
// Shared pipeline payload types and sizing helpers for the elastic stage.
package common_types_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        halt;
        logic [4:0]  rd;
        logic        dread;
        logic        dwrite;
        logic [1:0]  reg_wr_src;
        logic        reg_wr_mem;
        logic        reg_wr_mem_signed;
        logic        branch_pol;
        logic [1:0]  pc_ctrl;
        logic [31:0] rdat2;
        logic [31:0] alu_out;
        logic        alu_zero;
        logic [31:0] pc_plus_imm;
        logic        branch_predict;
        logic [31:0] branch_target;
    } ex_mem_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

    // Pointer width for a modulo-depth index; a single-entry buffer still needs one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_ptr_ctr.sv
// Modulo-DEPTH pointer with clear and increment; wraps DEPTH-1 -> 0 for any depth.
module pipe_ptr_ctr
    import common_types_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready elastic pipeline stage: DEPTH-entry circular buffer with flush and occupancy.
module pipe_stage_elastic
    import common_types_pkg::*;
#(
    parameter  int unsigned DATA_W     = 32,
    parameter  int unsigned DEPTH      = 2,
    parameter  int unsigned READY_PASS = 0,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    // A full stage may still accept when READY_PASS lets the concurrent pop free a slot.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !flush) begin
            in_ready = !full || ((READY_PASS != 0) && out_ready);
        end
    end

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    // Storage is deliberately not reset; out_data is qualified by out_valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                mem[i] <= in_data;
            end
        end
    end

    always_comb begin
        out_data = mem[0];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PTR_W'(i)) begin
                out_data = mem[i];
            end
        end
    end

endmodule
